// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state, mode and key definitions for the alarm ring controller
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [3:0] MODE_ALARM_SET = 4'b0101;

  localparam int KEY_DISMISS = 0;
  localparam int KEY_SNOOZE  = 1;

endpackage

// File: rtl/time_match_cmp.sv
// rtl/time_match_cmp.sv - combinational equality of two {meridiem, hour, min, sec} time tuples
module time_match_cmp (
  input  logic       a_meridiem,
  input  logic [6:0] a_hour,
  input  logic [6:0] a_min,
  input  logic [6:0] a_sec,
  input  logic       b_meridiem,
  input  logic [6:0] b_hour,
  input  logic [6:0] b_min,
  input  logic [6:0] b_sec,
  output logic       equal
);

  // Raw binary compare; out-of-range field values are not treated specially.
  assign equal = ({a_meridiem, a_hour, a_min, a_sec} == {b_meridiem, b_hour, b_min, b_sec});

endmodule

// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - alarm trigger/ring/snooze FSM with buzzer pattern; snooze built only with ALARM_SNOOZE_EN
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int         RING_SEC   = 60,
  parameter int         SNOOZE_MIN = 5,
  parameter logic [3:0] SET_MODE   = MODE_ALARM_SET
) (
  input  logic       RESET,
  input  logic       CLK,
  input  logic       TICK,
  input  logic       ARM,
  input  logic [3:0] MODE,
  input  logic [3:0] NUM_SYNC,
  input  logic       CUR_MERIDIEM,
  input  logic [6:0] CUR_HOUR,
  input  logic [6:0] CUR_MIN,
  input  logic [6:0] CUR_SEC,
  input  logic       ALM_MERIDIEM,
  input  logic [6:0] ALM_HOUR,
  input  logic [6:0] ALM_MIN,
  input  logic [6:0] ALM_SEC,
  output logic       RINGING,
  output logic       BUZZ,
  output logic       SNOOZED
);

  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

  state_t        state, state_nxt;
  logic [RW-1:0] ring_cnt, ring_cnt_nxt;
  logic          match, match_q;
  logic          force_stop, dismiss, snooze_key;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = (SNOOZE_MIN * 60 > 1) ? $clog2(SNOOZE_MIN * 60) : 1;
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_MIN * 60 - 1);
  logic [SW-1:0] snooze_cnt, snooze_cnt_nxt;
`endif

  time_match_cmp u_match (
    .a_meridiem (CUR_MERIDIEM),
    .a_hour     (CUR_HOUR),
    .a_min      (CUR_MIN),
    .a_sec      (CUR_SEC),
    .b_meridiem (ALM_MERIDIEM),
    .b_hour     (ALM_HOUR),
    .b_min      (ALM_MIN),
    .b_sec      (ALM_SEC),
    .equal      (match)
  );

  assign force_stop = ~ARM | (MODE == SET_MODE);
  assign dismiss    = NUM_SYNC[KEY_DISMISS];
  assign snooze_key = NUM_SYNC[KEY_SNOOZE];

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_nxt = snooze_cnt;
`endif
    if (force_stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Rising edge of match only, so a held match never re-triggers.
          if (match && !match_q) begin
            state_nxt    = RING;
            ring_cnt_nxt = '0;
          end
        end
        RING: begin
          if (dismiss) begin
            state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_key) begin
            state_nxt      = SNOOZE;
            snooze_cnt_nxt = SNOOZE_LOAD;
`else
          end else if (snooze_key) begin
            state_nxt = IDLE;
`endif
          end else if (TICK) begin
            if (ring_cnt == RING_LAST) state_nxt = IDLE;
            else                       ring_cnt_nxt = ring_cnt + 1'b1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (dismiss) begin
            state_nxt = IDLE;
          end else if (TICK) begin
            if (snooze_cnt == '0) begin
              state_nxt    = RING;
              ring_cnt_nxt = '0;
            end else begin
              snooze_cnt_nxt = snooze_cnt - 1'b1;
            end
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs come from the next-state decode so they are flops aligned with the state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      ring_cnt <= '0;
      match_q  <= 1'b1;
      RINGING  <= 1'b0;
      BUZZ     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_cnt_nxt;
      match_q  <= match;
      RINGING  <= (state_nxt == RING);
      BUZZ     <= (state_nxt == RING) & ~ring_cnt_nxt[0];
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      snooze_cnt <= '0;
      SNOOZED    <= 1'b0;
    end else begin
      snooze_cnt <= snooze_cnt_nxt;
      SNOOZED    <= (state_nxt == SNOOZE);
    end
  end
`else
  assign SNOOZED = 1'b0;
`endif

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Reads the alarm time produced by the alarm-set mode and the running clock time.
- Raises the alarm when the two match, then drives a buzzer pattern.
- Stops the alarm on dismiss, on timeout, when disarmed, or when the alarm-set mode is entered.
- Sits beside the alarm-set block: that block writes ALM_*, this block consumes them.

Parameters:
- RING_SEC, 60: number of TICKs the alarm rings before it stops by itself.
- SNOOZE_MIN, 5: snooze length in minutes; used only with ALARM_SNOOZE_EN.
- SET_MODE, 4'b0101: MODE code of alarm-set mode; matching is suppressed in this mode.

Ports:
- RESET  in  1  reset, asynchronous, active-low.
- CLK  in  1  clock.
- TICK  in  1  one-CLK pulse per second.
- ARM  in  1  alarm enable, level.
- MODE  in  4  current UI mode.
- NUM_SYNC  in  4  one-cycle key pulses. [0] = dismiss. [1] = snooze.
- CUR_MERIDIEM  in  1  current time, 0 = AM, 1 = PM.
- CUR_HOUR  in  7  current hour, binary 0..11.
- CUR_MIN  in  7  current minute, binary 0..59.
- CUR_SEC  in  7  current second, binary 0..59.
- ALM_MERIDIEM  in  1  alarm time, same encoding as CUR_MERIDIEM.
- ALM_HOUR  in  7  alarm hour, binary 0..11.
- ALM_MIN  in  7  alarm minute, binary 0..59.
- ALM_SEC  in  7  alarm second, binary 0..59.
- RINGING  out  1  high while in state RING.
- BUZZ  out  1  buzzer drive.
- SNOOZED  out  1  high while in state SNOOZE.

Behaviour:
- Reset (RESET low, asynchronous):
  - state = IDLE; RINGING = 0, BUZZ = 0, SNOOZED = 0.
  - ring_cnt = 0, snooze_cnt = 0.
  - match_q = 1, so equal times at reset release do not ring.
- match: all four field pairs equal, combinational. match_q registers match every cycle.
- Trigger condition: match & ~match_q & ARM & (MODE != SET_MODE).
- States: IDLE, RING, SNOOZE. All outputs are registered; RINGING and SNOOZED follow the state.
- IDLE -> RING on the trigger. RINGING rises the cycle after match rises. ring_cnt is cleared on entry.
- In RING:
  - On TICK, ring_cnt increments.
  - When ring_cnt reaches RING_SEC-1 and TICK is high, go to IDLE.
  - NUM_SYNC[0] -> IDLE.
  - NUM_SYNC[1] -> SNOOZE (feature only).
  - BUZZ = 1 when ring_cnt[0] = 0, else 0. This gives a 1 s on / 1 s off pattern.
- In SNOOZE:
  - snooze_cnt is loaded with SNOOZE_MIN*60-1 on entry.
  - On TICK, snooze_cnt decrements.
  - TICK with snooze_cnt = 0 -> RING, with ring_cnt cleared.
  - NUM_SYNC[0] -> IDLE.
- Forced stop: ARM = 0 or MODE == SET_MODE in any state -> IDLE next cycle. This has top priority.
- Priority within one cycle: forced stop > dismiss > snooze > TICK count/expiry.
- Other keys: NUM_SYNC[2] and NUM_SYNC[3] are ignored. NUM_SYNC[1] in IDLE is ignored.
- Keys [0] and [1] in the same cycle: dismiss wins.
- A new match while in RING or SNOOZE is ignored and does not restart counters.
- Widths: ring_cnt is $clog2(RING_SEC) bits. snooze_cnt is $clog2(SNOOZE_MIN*60) bits. No wrap: counters are only used inside their state.
- Out-of-range CUR_* or ALM_* values are compared as plain binary; no special handling.
- Reset mid-ring: immediate IDLE with all outputs 0.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined:
  - SNOOZE state and snooze_cnt exist.
  - NUM_SYNC[1] in RING enters SNOOZE.
  - SNOOZED is driven as specified.
- Undefined:
  - SNOOZE state and snooze_cnt are not built.
  - NUM_SYNC[1] acts exactly as dismiss (RING -> IDLE).
  - SNOOZED is tied to 0.

Decomposition:
- Shared package alarm_pkg:
  - state enum {IDLE, RING, SNOOZE}.
  - mode code constant MODE_ALARM_SET = 4'b0101.
  - key index constants KEY_DISMISS = 0, KEY_SNOOZE = 1.
- Sub-module time_match_cmp: purely combinational equality of the two {MERIDIEM, HOUR, MIN, SEC} tuples. It is reusable by other display or compare logic.
- The FSM and counters stay in alarm_ring_ctrl.

Test Plan:
- Arm and ring: ARM = 1, MODE = 0000, ALM = PM 7:30:00, CUR steps PM 7:29:59 -> 7:30:00 -> RINGING = 1 one cycle after the change; BUZZ = 1, then toggles each TICK.
- Auto-timeout: RING_SEC = 60, ring with no key -> RINGING falls on the 60th TICK; a continued match does not re-ring.
- Dismiss and forced stop: NUM_SYNC = 0001 in RING -> IDLE next cycle, BUZZ = 0. Separately, MODE = 0101 mid-ring -> IDLE. Separately, ARM = 0 before the match time -> no ring.
- Snooze (ALARM_SNOOZE_EN, SNOOZE_MIN = 1):
  - NUM_SYNC = 0010 in RING -> SNOOZED = 1, RINGING = 0.
  - After 60 TICKs -> RINGING = 1, SNOOZED = 0.
  - NUM_SYNC = 0011 in RING -> IDLE.
- Without the macro: NUM_SYNC = 0010 in RING -> IDLE and SNOOZED stays 0.
- Reset: CUR = ALM = AM 0:00:00, release RESET -> no ring. Assert RESET mid-ring -> all outputs 0 at once.
